// File: rtl/instr_sequencer_if.sv
// Control, program-load and instruction-issue signals between the sequencer and its
// controller. The sequencer uses the slave modport; the controller or bench uses master.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   prog_wen;
    logic [PC_BITS-1:0]     prog_addr;
    logic [INSTR_WIDTH-1:0] prog_data;
    logic                   start;
    logic                   pause;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [PC_BITS-1:0]     pc;
    logic                   busy;
    logic                   done;

    modport master (
        output prog_wen, prog_addr, prog_data, start, pause,
        input  instruction, instr_valid, pc, busy, done
    );

    modport slave (
        input  prog_wen, prog_addr, prog_data, start, pause,
        output instruction, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program ROM plus PC sequencer: fetches one word per ISSUE_CYCLES+1 cycles, presents it to
// the CPU with a one-cycle strobe, and stops on HALT_WORD or after the last address.
module instr_sequencer #(
    parameter int                     INSTR_WIDTH  = 20,
    parameter int                     PC_BITS      = 5,
    parameter int                     ISSUE_CYCLES = 4,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD    = 20'hFFFFF,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD     = 20'h00000
) (
    input  logic             clk,
    input  logic             rst,
    instr_sequencer_if.slave bus
);
    localparam int                   DEPTH    = 2 ** PC_BITS;
    localparam int                   CNT_BITS = $clog2(ISSUE_CYCLES + 1);
    localparam logic [PC_BITS-1:0]   LAST_PC  = '1;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);
    // HOLD starts at 1 and the ISSUE cycle itself counts as part of the hold window
    localparam logic [CNT_BITS-1:0]  CNT_EXIT = CNT_BITS'(ISSUE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] rom_rdata_q;
    logic                   prog_we;

    assign prog_we = bus.prog_wen && (state_q == S_IDLE || state_q == S_DONE);

    // Program memory is never reset so a loaded program survives rst
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
        rom_rdata_q <= mem[pc_q];
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                instr_d = NOP_WORD;
                if (bus.start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                instr_d = NOP_WORD;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (rom_rdata_q == HALT_WORD) begin
                    instr_d = NOP_WORD;
                    state_d = S_DONE;
                end else begin
                    instr_d = rom_rdata_q;
                    valid_d = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q >= CNT_EXIT) begin
                    // Counter saturates here while pause is held
                    if (!bus.pause) begin
                        cnt_d = '0;
                        if (pc_q == LAST_PC) begin
                            instr_d = NOP_WORD;
                            state_d = S_DONE;
                        end else begin
                            pc_d    = pc_q + PC_BITS'(1);
                            state_d = S_FETCH;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                instr_d = NOP_WORD;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: program load, issue timing, pause, halt, end of
// memory, asynchronous reset and busy-time write/start rejection.
module tb_instr_sequencer;
    localparam logic [19:0] HALT = 20'hFFFFF;
    localparam logic [19:0] NOP  = 20'h00000;

    logic clk;
    logic rst_n;

    instr_sequencer_if #(.INSTR_WIDTH(20), .PC_BITS(5)) bus ();

    instr_sequencer #(
        .INSTR_WIDTH (20),
        .PC_BITS     (5),
        .ISSUE_CYCLES(4),
        .HALT_WORD   (20'hFFFFF),
        .NOP_WORD    (20'h00000)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    int          st_q[$];
    logic [19:0] sw_q[$];
    int          unstable;
    int          prevalid_err;
    int          timeout;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish, expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [19:0] d);
        bus.prog_wen  = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tick();
        bus.prog_wen  = 1'b0;
    endtask

    // Starts a run and records every strobe; inj >= 0 drives a write+start at that cycle
    task automatic run(input int budget, input int inj, input logic wr_start,
                       input logic [4:0] wa, input logic [19:0] wd);
        logic [19:0] lw;
        int          ls;
        st_q.delete();
        sw_q.delete();
        unstable     = 0;
        prevalid_err = 0;
        timeout      = 1;
        ls           = -100;
        lw           = NOP;
        bus.start    = 1'b1;
        if (wr_start) begin
            bus.prog_wen  = 1'b1;
            bus.prog_addr = wa;
            bus.prog_data = wd;
        end
        tick();
        bus.start    = 1'b0;
        bus.prog_wen = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            tick();
            if (bus.done) begin
                timeout = 0;
                break;
            end
            if (bus.instr_valid) begin
                st_q.push_back(c);
                sw_q.push_back(bus.instruction);
                lw = bus.instruction;
                ls = c;
                $display("strobe cycle=%0d pc=%0d word=%05h", c, bus.pc, bus.instruction);
            end else if (c - ls <= 3 && bus.instruction !== lw) begin
                unstable++;
            end
            if (st_q.size() == 0 && !bus.instr_valid && bus.instruction !== NOP) prevalid_err++;
            if (c == inj) begin
                bus.start     = 1'b1;
                bus.prog_wen  = 1'b1;
                bus.prog_addr = wa;
                bus.prog_data = wd;
            end else begin
                bus.start    = 1'b0;
                bus.prog_wen = 1'b0;
            end
        end
        bus.start    = 1'b0;
        bus.prog_wen = 1'b0;
    endtask

    task automatic chk_prog1(input string tag, input logic [19:0] w1);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_nstrobe"}, st_q.size(), 3);
        if (st_q.size() == 3) begin
            chk({tag, "_t0"}, st_q[0], 2);
            chk({tag, "_t1"}, st_q[1], 7);
            chk({tag, "_t2"}, st_q[2], 12);
            chk({tag, "_w0"}, sw_q[0], 20'h12345);
            chk({tag, "_w1"}, sw_q[1], w1);
            chk({tag, "_w2"}, sw_q[2], 20'h00001);
        end
        chk({tag, "_stable"}, unstable, 0);
        chk({tag, "_nop_pre"}, prevalid_err, 0);
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_pc"}, bus.pc, 3);
        chk({tag, "_instr_done"}, bus.instruction, NOP);
    endtask

    initial begin
        int errs;
        rst_n         = 1'b0;
        bus.prog_wen  = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        tick();
        tick();
        chk("rst_instr", bus.instruction, NOP);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pc", bus.pc, 0);
        rst_n = 1'b1;
        tick();

        // Basic program with halt at address 3; also checks first-strobe latency
        wr(5'd0, 20'h12345);
        wr(5'd1, 20'h0ABCD);
        wr(5'd2, 20'h00001);
        wr(5'd3, HALT);
        run(100, -1, 1'b0, 5'd0, 20'h0);
        chk_prog1("t1", 20'h0ABCD);

        // Pause asserted from start: no effect until the first hold exit
        bus.pause = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("t3_issue_instr", bus.instruction, NOP);
        tick();
        chk("t3_first_valid", bus.instr_valid, 1);
        chk("t3_first_word", bus.instruction, 20'h12345);
        errs = 0;
        for (int c = 3; c <= 10; c++) begin
            tick();
            if (bus.instr_valid !== 1'b0 || bus.instruction !== 20'h12345 || bus.busy !== 1'b1)
                errs++;
        end
        chk("t3_paused_hold", errs, 0);
        chk("t3_paused_pc", bus.pc, 0);
        bus.pause = 1'b0;
        tick();
        chk("t3_release_pc", bus.pc, 1);
        chk("t3_release_valid", bus.instr_valid, 0);
        tick();
        chk("t3_issue2_valid", bus.instr_valid, 0);
        tick();
        chk("t3_second_valid", bus.instr_valid, 1);
        chk("t3_second_word", bus.instruction, 20'h0ABCD);
        for (int c = 0; c < 50 && !bus.done; c++) tick();
        chk("t3_done", bus.done, 1);
        chk("t3_pc", bus.pc, 3);

        // Asynchronous reset during the second instruction's hold
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 8; c++) tick();
        chk("t5_pre_pc", bus.pc, 1);
        chk("t5_pre_instr", bus.instruction, 20'h0ABCD);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_instr", bus.instruction, NOP);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_pc", bus.pc, 0);
        chk("t5_rst_valid", bus.instr_valid, 0);
        #2;
        rst_n = 1'b1;
        tick();
        run(100, -1, 1'b0, 5'd0, 20'h0);
        chk_prog1("t5_rerun", 20'h0ABCD);

        // Write and start while busy are ignored; after done a write+start takes effect
        run(100, 3, 1'b0, 5'd1, 20'h55555);
        chk_prog1("t6_busy", 20'h0ABCD);
        run(100, -1, 1'b1, 5'd1, 20'h55555);
        chk_prog1("t6_after", 20'h55555);

        // Full memory without halt: 32 issues, stop at pc 31 without wrapping
        for (int a = 0; a < 32; a++) wr(5'(a), 20'h00010);
        run(300, -1, 1'b0, 5'd0, 20'h0);
        chk("t4_timeout", timeout, 0);
        chk("t4_nstrobe", st_q.size(), 32);
        if (st_q.size() == 32) begin
            chk("t4_last_t", st_q[31], 157);
            errs = 0;
            foreach (sw_q[i]) if (sw_q[i] !== 20'h00010) errs++;
            chk("t4_words", errs, 0);
        end
        chk("t4_stable", unstable, 0);
        chk("t4_pc", bus.pc, 31);
        chk("t4_busy", bus.busy, 0);
        tick();
        tick();
        chk("t4_no_wrap_pc", bus.pc, 31);
        chk("t4_done_held", bus.done, 1);
        chk("t4_instr_done", bus.instruction, NOP);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
